// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART defaults, FSM state encoding and baud divisor helper (reused by uart_tx).
package uart_rx_pkg;
  localparam int DEF_CLK_HZ = 50_000_000;
  localparam int DEF_BAUD = 115_200;
  localparam int DEF_OVERSAMPLE = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic int baud_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status levels out to the IO block.
interface uart_rx_if;
  logic rxd;
  logic [7:0] data;
  logic done;
  logic frame_err;
  logic parity_err;
  logic busy;
  modport master(input rxd, output data, done, frame_err, parity_err, busy);
  modport slave(output rxd, input data, done, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every DIV clocks, held in phase zero while clr is high.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = !clr && cnt == W'(DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled with 3-sample majority vote.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx import uart_rx_pkg::*; #(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int BAUD = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input logic clk,
  input logic rst,
  uart_rx_if.master bus
);
  localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int M = OVERSAMPLE / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [1:0] sync;
  logic rxd_s, tick, decide, bit_end, s0, s1, vote, par, perr;
  logic [SW-1:0] scnt;
  logic [2:0] idx;
  logic [7:0] sh, data;
  logic done, frame_err, parity_err;
  assign rxd_s = sync[1];
  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .clr(state == IDLE), .tick(tick));
  assign decide = tick && scnt == SW'(M + 1);
  assign bit_end = tick && scnt == SW'(OVERSAMPLE - 1);
  assign vote = (s0 & s1) | (s0 & rxd_s) | (s1 & rxd_s);
  assign perr = PAR_EN && ((^sh) != par);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = rxd_s ? IDLE : START;
      START: state_n = (decide && vote) ? IDLE : bit_end ? DATA : START;
      DATA: state_n = (bit_end && idx == 3'd7) ? (PAR_EN ? PARITY : STOP) : DATA;
      PARITY: state_n = bit_end ? STOP : PARITY;
      STOP: state_n = decide ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // Stop is resolved mid-bit so a following start edge is never missed.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= 2'b11;
      scnt <= '0;
      idx <= '0;
      s0 <= 1'b0;
      s1 <= 1'b0;
      par <= 1'b0;
      sh <= '0;
      data <= '0;
      done <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      sync <= {sync[0], bus.rxd};
      scnt <= (state == IDLE || bit_end) ? '0 : tick ? scnt + 1'b1 : scnt;
      if (state == IDLE) idx <= '0;
      else if (state == DATA && bit_end) idx <= idx + 1'b1;
      if (tick && scnt == SW'(M - 1)) s0 <= rxd_s;
      if (tick && scnt == SW'(M)) s1 <= rxd_s;
      if (state == START && decide && !vote) begin
        done <= 1'b0;
        frame_err <= 1'b0;
        parity_err <= 1'b0;
      end
      if (state == DATA && decide) sh <= {vote, sh[7:1]};
      if (state == PARITY && decide) par <= vote;
      if (state == STOP && decide) begin
        frame_err <= !vote;
        parity_err <= perr;
        if (vote && !perr) begin
          data <= sh;
          done <= 1'b1;
        end
      end
    end
  assign bus.data = data;
  assign bus.done = done;
  assign bus.frame_err = frame_err;
  assign bus.parity_err = parity_err;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at DIV=1 (16 clocks per bit) with hand-computed expectations.
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = 157 + 16 * P;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0, errs = 0, cyc = 0, t_start = 0, t_rise = 0, lat;
  logic done_q = 1'b0;
  uart_rx_if bus();
  uart_rx #(.CLK_HZ(1600000), .BAUD(100000), .OVERSAMPLE(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (bus.done && !done_q) t_rise = cyc;
    done_q = bus.done;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop_b, input logic par_ok, input int spike);
    logic [10:0] f;
    int n;
    n = 10 + P;
    f = {2'b11, b, 1'b0};
    if (P == 1) begin
      f[9] = (^b) ^ !par_ok;
      f[10] = stop_b;
    end else f[9] = stop_b;
    t_start = cyc;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 16; j++) begin
        bus.rxd = (i == spike && j == 9) ? !f[i] : f[i];
        @(negedge clk);
      end
    bus.rxd = 1'b1;
  endtask
  initial begin
    bus.rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", bus.data, 0);
    check("rst_done", bus.done, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_perr", bus.parity_err, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send(8'hA5, 1'b1, 1'b1, -1);
    lat = t_rise - t_start;
    check("a5_latency_ok", (lat >= LAT - 3 && lat <= LAT + 3), 1);
    check("a5_data", bus.data, 8'hA5);
    check("a5_done", bus.done, 1);
    check("a5_ferr", bus.frame_err, 0);
    check("a5_busy", bus.busy, 0);
    repeat (500) @(negedge clk);
    check("a5_done_held", bus.done, 1);
    check("a5_data_held", bus.data, 8'hA5);
    send(8'h00, 1'b1, 1'b1, -1);
    check("b2b_first_data", bus.data, 8'h00);
    check("b2b_first_done", bus.done, 1);
    fork
      send(8'hFF, 1'b1, 1'b1, -1);
      begin
        repeat (24) @(negedge clk);
        check("b2b_done_fall", bus.done, 0);
        check("b2b_busy", bus.busy, 1);
      end
    join
    check("b2b_second_data", bus.data, 8'hFF);
    check("b2b_second_done", bus.done, 1);
    bus.rxd = 1'b0;
    repeat (4) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", bus.busy, 1);
    repeat (30) @(negedge clk);
    check("glitch_busy_end", bus.busy, 0);
    check("glitch_done", bus.done, 1);
    check("glitch_data", bus.data, 8'hFF);
    check("glitch_ferr", bus.frame_err, 0);
    check("glitch_perr", bus.parity_err, 0);
    send(8'h00, 1'b1, 1'b1, 4);
    check("spike_data", bus.data, 8'h00);
    check("spike_done", bus.done, 1);
    check("spike_ferr", bus.frame_err, 0);
    send(8'h3C, 1'b0, 1'b1, -1);
    repeat (40) @(negedge clk);
    check("ferr_set", bus.frame_err, 1);
    check("ferr_done", bus.done, 0);
    check("ferr_data_kept", bus.data, 8'h00);
    send(8'h11, 1'b1, 1'b1, -1);
    check("recover_ferr", bus.frame_err, 0);
    check("recover_done", bus.done, 1);
    check("recover_data", bus.data, 8'h11);
    fork
      send(8'h5A, 1'b1, 1'b1, -1);
      begin
        repeat (80) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_data", bus.data, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_ferr", bus.frame_err, 0);
      end
    join
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_done", bus.done, 0);
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, -1);
    check("par_bad_perr", bus.parity_err, 1);
    check("par_bad_done", bus.done, 0);
    check("par_bad_data", bus.data, 0);
    send(8'h07, 1'b1, 1'b1, -1);
    check("par_ok_perr", bus.parity_err, 0);
    check("par_ok_done", bus.done, 1);
    check("par_ok_data", bus.data, 8'h07);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
